alu_sched: RTL

Round-robin scheduler that shares one structural ALU instance among NREQ requesters. It accepts one operation per transaction over a valid/ready handshake and decodes a compact opcode into the ALU's shift/logic/class/add_sub/const controls. It registers the ALU result and flags, then returns them with the requester ID over a valid/ready response channel. It sits between client engines and the combinational ALU, and owns all ALU control inputs.

---
 rtl/alu_sched_pkg.sv | 20 ++
 rtl/alu_sched_decode.sv | 29 ++
 rtl/alu_sched.sv | 113 +++++++++++
 3 files changed

// File: rtl/alu_sched_pkg.sv
// alu_sched_pkg: opcode set, ALU control encodings and decoded control bundle
package alu_sched_pkg;
  typedef enum logic [3:0] {
    OP_PASS = 4'h0, OP_SLL = 4'h1, OP_SRL = 4'h2, OP_SRA = 4'h3,
    OP_SLLV = 4'h4, OP_SRLV = 4'h5, OP_SRAV = 4'h6, OP_SLT = 4'h7,
    OP_ADD = 4'h8, OP_SUB = 4'h9, OP_AND = 4'hA, OP_OR = 4'hB,
    OP_XOR = 4'hC, OP_NOR = 4'hD, OP_ILL_E = 4'hE, OP_ILL_F = 4'hF
  } alu_op_e;
  localparam logic [1:0] FC_SHIFT = 2'b00, FC_SLT = 2'b01, FC_ARITH = 2'b10, FC_LOGIC = 2'b11;
  localparam logic [1:0] SH_SLL = 2'b00, SH_SRL = 2'b10, SH_SRA = 2'b11;
  localparam logic [1:0] LF_AND = 2'b00, LF_OR = 2'b01, LF_XOR = 2'b10, LF_NOR = 2'b11;
  typedef struct packed {
    logic [1:0] shift_func;
    logic [1:0] logic_func;
    logic [1:0] func_class;
    logic       add_sub;
    logic       const_var;
    logic       illegal;
  } alu_ctrl_t;
endpackage

// File: rtl/alu_sched_decode.sv
// alu_op_decode: maps a compact opcode onto the ALU control bundle
module alu_op_decode
  import alu_sched_pkg::*;
(
  input  alu_op_e   op,
  output alu_ctrl_t ctrl
);
  // PASS and illegal opcodes fall through to the all-zero bundle, i.e. a shift-left of y by zero
  always_comb begin
    ctrl = '0;
    case (op)
      OP_SLL:  ctrl.shift_func = SH_SLL;
      OP_SRL:  ctrl.shift_func = SH_SRL;
      OP_SRA:  ctrl.shift_func = SH_SRA;
      OP_SLLV: begin ctrl.shift_func = SH_SLL; ctrl.const_var = 1'b1; end
      OP_SRLV: begin ctrl.shift_func = SH_SRL; ctrl.const_var = 1'b1; end
      OP_SRAV: begin ctrl.shift_func = SH_SRA; ctrl.const_var = 1'b1; end
      OP_SLT:  begin ctrl.func_class = FC_SLT; ctrl.add_sub = 1'b1; end
      OP_ADD:  ctrl.func_class = FC_ARITH;
      OP_SUB:  begin ctrl.func_class = FC_ARITH; ctrl.add_sub = 1'b1; end
      OP_AND:  begin ctrl.func_class = FC_LOGIC; ctrl.logic_func = LF_AND; end
      OP_OR:   begin ctrl.func_class = FC_LOGIC; ctrl.logic_func = LF_OR; end
      OP_XOR:  begin ctrl.func_class = FC_LOGIC; ctrl.logic_func = LF_XOR; end
      OP_NOR:  begin ctrl.func_class = FC_LOGIC; ctrl.logic_func = LF_NOR; end
      OP_ILL_E, OP_ILL_F: ctrl.illegal = 1'b1;
      default: ;
    endcase
  end
endmodule

// File: rtl/alu_sched.sv
// alu_sched: round-robin sharing of one combinational ALU; ALU_OVFL_TRAP_EN turns ADD/SUB overflow into an error response
module alu_sched
  import alu_sched_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int NREQ = 4,
  localparam int IDW = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*4-1:0]     req_op,
  input  logic [NREQ*WIDTH-1:0] req_x,
  input  logic [NREQ*WIDTH-1:0] req_y,
  input  logic [NREQ*5-1:0]     req_shamt,
  output logic [WIDTH-1:0]      alu_x,
  output logic [WIDTH-1:0]      alu_y,
  output logic [1:0]            alu_shift_func,
  output logic [1:0]            alu_logic_func,
  output logic [1:0]            alu_func_class,
  output logic                  alu_add_sub,
  output logic                  alu_const_var,
  output logic [4:0]            alu_const_amt,
  input  logic [WIDTH-1:0]      alu_s,
  input  logic                  alu_zero,
  input  logic                  alu_ovfl,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [IDW-1:0]        rsp_id,
  output logic [WIDTH-1:0]      rsp_s,
  output logic                  rsp_zero,
  output logic                  rsp_ovfl,
  output logic                  rsp_err
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_e;
  state_e state, state_nx;
  logic [IDW-1:0] rr_ptr, win, idx, id_q;
  logic found, trap, kill;
  alu_op_e op_q;
  logic [WIDTH-1:0] x_q, y_q;
  logic [4:0] shamt_q;
  alu_ctrl_t ctrl;
  alu_op_decode u_dec (.op(op_q), .ctrl(ctrl));
  // Scan from the highest offset down so the requester nearest rr_ptr is the last, winning, assignment
  always_comb begin
    found = 1'b0;
    win = '0;
    idx = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = IDW'((int'(rr_ptr) + k) % NREQ);
      if (req_valid[idx]) begin
        found = 1'b1;
        win = idx;
      end
    end
  end
  assign req_ready = (rst_n && state == IDLE && found) ? NREQ'(1) << win : '0;
  assign rsp_valid = state == RESP;
  assign rsp_id = id_q;
  assign alu_x = x_q;
  assign alu_y = y_q;
  assign alu_shift_func = ctrl.shift_func;
  assign alu_logic_func = ctrl.logic_func;
  assign alu_func_class = ctrl.func_class;
  assign alu_add_sub = ctrl.add_sub;
  assign alu_const_var = ctrl.const_var;
  assign alu_const_amt = (op_q == OP_PASS || ctrl.illegal) ? 5'd0 : shamt_q;
`ifdef ALU_OVFL_TRAP_EN
  assign trap = ctrl.func_class == FC_ARITH && alu_ovfl;
`else
  assign trap = 1'b0;
`endif
  assign kill = ctrl.illegal || trap;
  // State register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  // Accept in IDLE, execute for exactly one cycle, then hold the response until taken
  always_comb begin
    state_nx = state;
    state_nx = state == IDLE ? (found ? EXEC : IDLE) : state == EXEC ? RESP : (rsp_ready ? IDLE : RESP);
  end
  // Latch the granted request, advance the pointer past the winner, and capture the ALU result in EXEC
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rr_ptr <= '0;
      id_q <= '0;
      op_q <= OP_PASS;
      x_q <= '0;
      y_q <= '0;
      shamt_q <= '0;
      rsp_s <= '0;
      rsp_zero <= 1'b0;
      rsp_ovfl <= 1'b0;
      rsp_err <= 1'b0;
    end else begin
      if (state == IDLE && found) begin
        op_q <= alu_op_e'(req_op[4*win +: 4]);
        x_q <= req_x[WIDTH*win +: WIDTH];
        y_q <= req_y[WIDTH*win +: WIDTH];
        shamt_q <= req_shamt[5*win +: 5];
        id_q <= win;
        rr_ptr <= (win == IDW'(NREQ - 1)) ? '0 : win + 1'b1;
      end
      if (state == EXEC) begin
        rsp_s <= kill ? '0 : alu_s;
        rsp_zero <= !kill && alu_zero;
        rsp_ovfl <= ctrl.func_class == FC_ARITH && alu_ovfl;
        rsp_err <= kill;
      end
    end
endmodule
